// File: rtl/srlatch_dr_driver.sv
// Clocked four-phase initiator for a dual-rail SR latch, with a reference model of the latch state.
// Optional wait-phase watchdog enabled by defining DRV_TIMEOUT_EN.
module srlatch_dr_driver #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_set,
  input  logic       req_reset,
  output logic       IPTG0,
  output logic       IPTG1,
  output logic       aTc0,
  output logic       aTc1,
  input  logic       GFP0,
  input  logic       GFP1,
  output logic       rsp_valid,
  output logic       rsp_q,
  output logic [1:0] rsp_err,
  output logic       rsp_mismatch,
  output logic       model_q
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("srlatch_dr_driver: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    HOLD      = 3'd2,
    NULL_DRV  = 3'd3,
    WAIT_NULL = 3'd4,
    RESP      = 3'd5
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [3:0]             rails, rails_nxt;  // {IPTG1, IPTG0, aTc1, aTc0}
  logic                   pred, pred_nxt;
  logic [1:0]             err, err_nxt;
  logic                   q_cap, q_cap_nxt;
  logic [7:0]             hold_cnt, hold_cnt_nxt;
  logic                   rsp_valid_nxt, rsp_q_nxt, rsp_mismatch_nxt, model_q_nxt;
  logic [1:0]             rsp_err_nxt;
  logic                   go_resp;
  logic [SYNC_STAGES-1:0] sync0, sync1;
  logic                   g0, g1;
  logic                   tmo_hit;

  assign g0 = sync0[SYNC_STAGES-1];
  assign g1 = sync1[SYNC_STAGES-1];

  assign IPTG1 = rails[3];
  assign IPTG0 = rails[2];
  assign aTc1  = rails[1];
  assign aTc0  = rails[0];

  // GFP rails arrive from the asynchronous latch and are brought in through a flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= {sync0[SYNC_STAGES-2:0], GFP0};
      sync1 <= {sync1[SYNC_STAGES-2:0], GFP1};
    end
  end

`ifdef DRV_TIMEOUT_EN
  logic [15:0] tmo_cnt, tmo_cnt_nxt;

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES));

  // Counter restarts whenever a wait state is entered
  always_comb begin
    tmo_cnt_nxt = 16'd0;
    if ((state == WAIT_DATA || state == WAIT_NULL) && state_nxt == state) begin
      tmo_cnt_nxt = tmo_cnt + 16'd1;
    end else begin
      tmo_cnt_nxt = 16'd0;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 16'd0;
    end else begin
      tmo_cnt <= tmo_cnt_nxt;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and next-output logic for the four-phase handshake
  always_comb begin
    state_nxt        = state;
    rails_nxt        = rails;
    pred_nxt         = pred;
    err_nxt          = err;
    q_cap_nxt        = q_cap;
    hold_cnt_nxt     = hold_cnt;
    rsp_valid_nxt    = 1'b0;
    rsp_q_nxt        = rsp_q;
    rsp_err_nxt      = rsp_err;
    rsp_mismatch_nxt = rsp_mismatch;
    model_q_nxt      = model_q;
    go_resp          = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_set && req_reset) begin
          rsp_valid_nxt    = 1'b1;
          rsp_q_nxt        = model_q;
          rsp_err_nxt      = 2'd1;
          rsp_mismatch_nxt = 1'b0;
        end else if (req_valid) begin
          rails_nxt = {req_set, ~req_set, req_reset, ~req_reset};
          pred_nxt  = req_set ? 1'b1 : (req_reset ? 1'b0 : model_q);
          err_nxt   = 2'd0;
          q_cap_nxt = model_q;
          state_nxt = WAIT_DATA;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_DATA: begin
        if (g0 ^ g1) begin
          q_cap_nxt    = g1;
          hold_cnt_nxt = 8'd0;
          state_nxt    = HOLD;
        end else if (g0 && g1) begin
          err_nxt   = 2'd2;
          rails_nxt = 4'b0000;
          state_nxt = NULL_DRV;
        end else if (tmo_hit) begin
          err_nxt   = 2'd3;
          rails_nxt = 4'b0000;
          state_nxt = NULL_DRV;
        end else begin
          state_nxt = WAIT_DATA;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          rails_nxt = 4'b0000;
          state_nxt = NULL_DRV;
        end else begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
      end
      NULL_DRV: begin
        state_nxt = WAIT_NULL;
      end
      WAIT_NULL: begin
        if (!g0 && !g1) begin
          go_resp = 1'b1;
        end else if (tmo_hit) begin
          err_nxt = 2'd3;
          go_resp = 1'b1;
        end else if (g0 && g1) begin
          err_nxt = 2'd2;
        end else begin
          err_nxt = err;
        end
        // Response fields are registered on the way into RESP so they line up with rsp_valid
        if (go_resp) begin
          state_nxt        = RESP;
          rsp_valid_nxt    = 1'b1;
          rsp_q_nxt        = q_cap;
          rsp_err_nxt      = err_nxt;
          rsp_mismatch_nxt = (err_nxt == 2'd0) && (q_cap != pred);
          model_q_nxt      = (err_nxt == 2'd0) ? q_cap : model_q;
        end else begin
          state_nxt = WAIT_NULL;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        rails_nxt = 4'b0000;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rails        <= 4'b0000;
      pred         <= 1'b0;
      err          <= 2'd0;
      q_cap        <= 1'b0;
      hold_cnt     <= 8'd0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_q        <= 1'b0;
      rsp_err      <= 2'd0;
      rsp_mismatch <= 1'b0;
      model_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      rails        <= rails_nxt;
      pred         <= pred_nxt;
      err          <= err_nxt;
      q_cap        <= q_cap_nxt;
      hold_cnt     <= hold_cnt_nxt;
      req_ready    <= (state_nxt == IDLE);
      rsp_valid    <= rsp_valid_nxt;
      rsp_q        <= rsp_q_nxt;
      rsp_err      <= rsp_err_nxt;
      rsp_mismatch <= rsp_mismatch_nxt;
      model_q      <= model_q_nxt;
    end
  end

endmodule

// File: tb/tb_srlatch_dr_driver.sv
// Directed, table-driven bench for srlatch_dr_driver with a behavioural dual-rail latch
// that answers 4 cycles after the rails change.
module tb_srlatch_dr_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_set = 1'b0;
  logic       req_reset = 1'b0;
  logic       req_ready;
  logic       IPTG0, IPTG1, aTc0, aTc1;
  logic       GFP0 = 1'b0;
  logic       GFP1 = 1'b0;
  logic       rsp_valid, rsp_q, rsp_mismatch, model_q;
  logic [1:0] rsp_err;

  int passed = 0;
  int total  = 0;

  // latch behaviour: 0 real latch, 1 forced value, 2 both rails high, 3 silent
  int         lat_mode  = 0;
  logic       lat_force = 1'b0;
  logic       lat_q     = 1'b0;
  logic [3:0] rd0 = 4'b0, rd1 = 4'b0, rd2 = 4'b0;

  srlatch_dr_driver #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_reset(req_reset),
    .IPTG0(IPTG0), .IPTG1(IPTG1), .aTc0(aTc0), .aTc1(aTc1),
    .GFP0(GFP0), .GFP1(GFP1),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_err(rsp_err),
    .rsp_mismatch(rsp_mismatch), .model_q(model_q)
  );

  always #5 clk = ~clk;

  function automatic logic next_q(input logic [3:0] r, input logic q);
    if (r[3]) return 1'b1;
    else if (r[1]) return 1'b0;
    else return q;
  endfunction

  always @(posedge clk) begin
    rd0 <= {IPTG1, IPTG0, aTc1, aTc0};
    rd1 <= rd0;
    rd2 <= rd1;
    if (rd2 == 4'b0000) begin
      GFP1 <= 1'b0; GFP0 <= 1'b0;
    end else begin
      case (lat_mode)
        0: begin
          lat_q <= next_q(rd2, lat_q);
          GFP1  <= next_q(rd2, lat_q);
          GFP0  <= ~next_q(rd2, lat_q);
        end
        1: begin GFP1 <= lat_force;  GFP0 <= ~lat_force; end
        2: begin GFP1 <= 1'b1;       GFP0 <= 1'b1; end
        default: begin GFP1 <= 1'b0; GFP0 <= 1'b0; end
      endcase
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] rails_now();
    return {IPTG1, IPTG0, aTc1, aTc0};
  endfunction

  typedef struct {
    logic       s;
    logic       r;
    int         mode;
    logic       frc;
    logic [3:0] code;
    logic       q;
    logic       chk_q;
    logic [1:0] err;
    logic       mis;
    logic       mq;
  } vec_t;

  vec_t tbl[9];

  task automatic accept(input logic s, input logic r);
    @(negedge clk);
    check("ready_before_req", {7'd0, req_ready}, 8'd1);
    req_valid = 1'b1; req_set = s; req_reset = r;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_set = 1'b0; req_reset = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_seen"}, {7'd0, rsp_valid}, 8'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    lat_mode = v.mode; lat_force = v.frc;
    accept(v.s, v.r);
    if (v.s && v.r) begin
      check({tag, "_illegal_pulse"}, {7'd0, rsp_valid}, 8'd1);
      check({tag, "_no_rails"}, {4'd0, rails_now()}, 8'd0);
    end else begin
      check({tag, "_code"}, {4'd0, rails_now()}, {4'd0, v.code});
      check({tag, "_busy"}, {7'd0, req_ready}, 8'd0);
      wait_rsp(tag);
      check({tag, "_null_at_rsp"}, {4'd0, rails_now()}, 8'd0);
    end
    if (v.chk_q) check({tag, "_q"}, {7'd0, rsp_q}, {7'd0, v.q});
    check({tag, "_err"}, {6'd0, rsp_err}, {6'd0, v.err});
    check({tag, "_mis"}, {7'd0, rsp_mismatch}, {7'd0, v.mis});
    check({tag, "_model"}, {7'd0, model_q}, {7'd0, v.mq});
    @(negedge clk);
    check({tag, "_pulse_end"}, {6'd0, rsp_valid, req_ready}, 8'd1);
  endtask

  initial begin
    //            s     r     mode frc   code     q     chk   err   mis   mq
    tbl[0] = '{1'b1, 1'b0, 0, 1'b0, 4'b1001, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 0, 1'b0, 4'b0101, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1, 1'b1, 4'b0110, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 0, 1'b0, 4'b0110, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 2, 1'b0, 4'b1001, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 0, 1'b0, 4'b1001, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1, 1'b0, 4'b0101, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 0, 1'b0, 4'b0101, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_rails", {4'd0, rails_now()}, 8'd0);
    check("reset_outs", {3'd0, req_ready, rsp_valid, rsp_q, rsp_mismatch, model_q}, 8'b0001_0000);
    check("reset_err", {6'd0, rsp_err}, 8'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

`ifdef DRV_TIMEOUT_EN
    begin
      int n = 0;
      lat_mode = 3;
      accept(1'b1, 1'b0);
      check("tmo_code", {4'd0, rails_now()}, 8'b0000_1001);
      while (rails_now() != 4'b0000 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("tmo_null_delay", 8'(n), 8'd17);
      wait_rsp("tmo");
      check("tmo_err", {6'd0, rsp_err}, 8'd3);
      check("tmo_model", {7'd0, model_q}, 8'd1);
      @(negedge clk);
    end
`endif

    // reset in the middle of HOLD: rails drop, no response, model cleared
    begin
      int seen = 0;
      lat_mode = 0;
      accept(1'b0, 1'b1);
      repeat (8) @(negedge clk);
      check("midhold_active", {4'd0, rails_now()}, 8'b0000_0110);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midhold_rails", {4'd0, rails_now()}, 8'd0);
      check("midhold_state", {5'd0, req_ready, rsp_valid, model_q}, 8'b0000_0100);
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      check("midhold_no_rsp", 8'(seen), 8'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
